// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch-stage program-counter block:
//   - fetch_state_e : 2-bit FSM encoding (ST_BOOT, ST_RUN, ST_PEND)
//   - DEF_RESET_PC  : default pc_F value after reset
//   - DEF_IM_BASE   : default byte address mapped to IM word index 0
// -----------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } fetch_state_e;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
   localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;

endpackage

// File: rtl/im_addr_gen.sv
// -----------------------------------------------------------------------------
// im_addr_gen
// Purely combinational translation of a fetch byte address into the
// instruction-memory word address:
//   im_addr = (((pc - IM_BASE) >> 2) + WORD_OFFSET) mod 2^IM_ADDR_W
// The subtraction wraps modulo 2^PC_W.
//
// Optional feature (macro IM_RANGE_CHECK_EN): adds range_fault, high when pc
// lies below IM_BASE or its word index is at or beyond IM_DEPTH.
//
// Ports:
//   pc          in   PC_W       fetch byte address
//   im_addr     out  IM_ADDR_W  IM word address
//   range_fault out  1          pc outside the populated IM (macro only)
// -----------------------------------------------------------------------------
module im_addr_gen #(
   parameter int              PC_W        = 32,
   parameter int              IM_ADDR_W   = 11,
   parameter logic [PC_W-1:0] IM_BASE     = PC_W'(32'h0000_3000),
   parameter int              WORD_OFFSET = 1
`ifdef IM_RANGE_CHECK_EN
   ,
   parameter int              IM_DEPTH    = 1024
`endif
) (
   input  logic [PC_W-1:0]      pc,
   output logic [IM_ADDR_W-1:0] im_addr
`ifdef IM_RANGE_CHECK_EN
   ,
   output logic                 range_fault
`endif
);

   // Byte offset from the IM base; wraps naturally for addresses below base.
   logic [PC_W-1:0] offset_s;

   assign offset_s = pc - IM_BASE;

   // Word index plus offset, truncated to the IM address width.
   assign im_addr = IM_ADDR_W'(offset_s >> 2) + IM_ADDR_W'(WORD_OFFSET);

`ifdef IM_RANGE_CHECK_EN
   // Below-base check is needed because the wrapped offset alone would look
   // like a huge index only when it exceeds IM_DEPTH; be explicit about both.
   assign range_fault = (pc < IM_BASE) ||
                        ((offset_s >> 2) >= PC_W'(IM_DEPTH));
`endif

endmodule

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
// Fetch-stage program counter for the pipelined MIPS core. Holds pc_F,
// generates the IM word address, applies stall hold and branch/jump
// redirects. A redirect arriving while the fetch stage is stalled is
// buffered (last one wins) and applied on the first unstalled cycle unless
// a live redirect in that same cycle supersedes it.
//
// FSM: ST_BOOT (one settle cycle after reset, no fetch), ST_RUN (normal),
//      ST_PEND (a buffered redirect is waiting, held instruction is stale).
//
// Optional feature (macro IM_RANGE_CHECK_EN): output range_fault_F; while it
// is high, fetch_valid is 0 and pc_F only moves on a redirect or reset.
//
// Ports:
//   clk            in   1          system clock, rising edge
//   reset          in   1          synchronous active-high reset
//   stall_F        in   1          hold pc_F this cycle
//   redirect_valid in   1          branch/jump target valid
//   redirect_pc    in   PC_W       target byte address
//   pc_F           out  PC_W       current fetch PC (registered)
//   pc4_F          out  PC_W       pc_F + 4
//   im_addr        out  IM_ADDR_W  IM word address from pc_F
//   fetch_valid    out  1          instruction at pc_F is on the correct path
//   pend_valid     out  1          buffered redirect waiting (registered)
//   misalign_F     out  1          pc_F[1:0] != 0
//   range_fault_F  out  1          pc_F outside IM (macro only)
// -----------------------------------------------------------------------------
module fetch_pc_unit
   import fetch_pkg::*;
#(
   parameter int              PC_W        = 32,
   parameter int              IM_ADDR_W   = 11,
   parameter logic [PC_W-1:0] RESET_PC    = PC_W'(DEF_RESET_PC),
   parameter logic [PC_W-1:0] IM_BASE     = PC_W'(DEF_IM_BASE),
   parameter int              WORD_OFFSET = 1,
   parameter int              IM_DEPTH    = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall_F,
   input  logic                 redirect_valid,
   input  logic [PC_W-1:0]      redirect_pc,
   output logic [PC_W-1:0]      pc_F,
   output logic [PC_W-1:0]      pc4_F,
   output logic [IM_ADDR_W-1:0] im_addr,
   output logic                 fetch_valid,
   output logic                 pend_valid,
   output logic                 misalign_F
`ifdef IM_RANGE_CHECK_EN
   ,
   output logic                 range_fault_F
`endif
);

   fetch_state_e    state_r;
   logic [PC_W-1:0] pc_r;
   logic [PC_W-1:0] pend_pc_r;
   logic            pend_valid_r;
   logic            seq_ok_s;     // sequential +4 advance permitted
   logic [PC_W-1:0] pc_plus4_s;

   assign pc_plus4_s = pc_r + PC_W'(4);

`ifdef IM_RANGE_CHECK_EN
   logic range_fault_s;

   im_addr_gen #(
      .PC_W        (PC_W),
      .IM_ADDR_W   (IM_ADDR_W),
      .IM_BASE     (IM_BASE),
      .WORD_OFFSET (WORD_OFFSET),
      .IM_DEPTH    (IM_DEPTH)
   ) u_im_addr_gen (
      .pc          (pc_r),
      .im_addr     (im_addr),
      .range_fault (range_fault_s)
   );

   assign range_fault_F = range_fault_s;
   assign seq_ok_s      = !range_fault_s;
`else
   im_addr_gen #(
      .PC_W        (PC_W),
      .IM_ADDR_W   (IM_ADDR_W),
      .IM_BASE     (IM_BASE),
      .WORD_OFFSET (WORD_OFFSET)
   ) u_im_addr_gen (
      .pc          (pc_r),
      .im_addr     (im_addr)
   );

   assign seq_ok_s = 1'b1;
`endif

   // FSM, PC register and pending-redirect buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_BOOT;
         pc_r         <= RESET_PC;
         pend_pc_r    <= '0;
         pend_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_BOOT: begin
               // PC is not advanced while the IM read settles.
               if (redirect_valid) begin
                  pend_pc_r    <= redirect_pc;
                  pend_valid_r <= 1'b1;
                  state_r      <= ST_PEND;
               end else begin
                  state_r      <= ST_RUN;
               end
            end
            ST_RUN, ST_PEND: begin
               if (stall_F) begin
                  // Hold pc_r; a redirect during stall overwrites the buffer.
                  if (redirect_valid) begin
                     pend_pc_r    <= redirect_pc;
                     pend_valid_r <= 1'b1;
                     state_r      <= ST_PEND;
                  end else begin
                     state_r      <= state_r;
                  end
               end else if (redirect_valid) begin
                  // Live redirect beats a buffered one.
                  pc_r         <= redirect_pc;
                  pend_valid_r <= 1'b0;
                  state_r      <= ST_RUN;
               end else if (pend_valid_r) begin
                  pc_r         <= pend_pc_r;
                  pend_valid_r <= 1'b0;
                  state_r      <= ST_RUN;
               end else if (seq_ok_s) begin
                  pc_r         <= pc_plus4_s;
                  state_r      <= ST_RUN;
               end else begin
                  state_r      <= ST_RUN;
               end
            end
            default: begin
               // Unreachable encoding: recover through a clean boot.
               state_r      <= ST_BOOT;
               pend_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign pc_F        = pc_r;
   assign pc4_F       = pc_plus4_s;
   assign pend_valid  = pend_valid_r;
   assign misalign_F  = (pc_r[1:0] != 2'b00);
   // Decoded purely from flops, so glitch-free for downstream capture.
   assign fetch_valid = (state_r == ST_RUN) && !pend_valid_r && seq_ok_s;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
// Directed self-checking bench for fetch_pc_unit. Inputs are driven and
// outputs sampled on the falling clock edge. With IM_RANGE_CHECK_EN defined
// the DUT is built with IM_DEPTH = 4 and the range-fault sequence is run.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

   logic        clk;
   logic        reset;
   logic        stall_F;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] pc_F;
   logic [31:0] pc4_F;
   logic [10:0] im_addr;
   logic        fetch_valid;
   logic        pend_valid;
   logic        misalign_F;
`ifdef IM_RANGE_CHECK_EN
   logic        range_fault_F;
   localparam int TB_IM_DEPTH = 4;
`else
   localparam int TB_IM_DEPTH = 1024;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   fetch_pc_unit #(
      .PC_W        (32),
      .IM_ADDR_W   (11),
      .RESET_PC    (32'h0000_3000),
      .IM_BASE     (32'h0000_3000),
      .WORD_OFFSET (1),
      .IM_DEPTH    (TB_IM_DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .stall_F        (stall_F),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .pc_F           (pc_F),
      .pc4_F          (pc4_F),
      .im_addr        (im_addr),
      .fetch_valid    (fetch_valid),
      .pend_valid     (pend_valid),
      .misalign_F     (misalign_F)
`ifdef IM_RANGE_CHECK_EN
      ,
      .range_fault_F  (range_fault_F)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Checks the main observable fetch state against hand-computed values.
   task automatic expect_f(input string tag, input logic [31:0] e_pc,
                           input logic [31:0] e_im, input logic e_fv,
                           input logic e_pend);
      check_eq({tag, "_pc"},   pc_F,                 e_pc);
      check_eq({tag, "_pc4"},  pc4_F,                e_pc + 32'd4);
      check_eq({tag, "_im"},   {21'd0, im_addr},     e_im);
      check_eq({tag, "_fv"},   {31'd0, fetch_valid}, {31'd0, e_fv});
      check_eq({tag, "_pend"}, {31'd0, pend_valid},  {31'd0, e_pend});
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset          = 1'b1;
      stall_F        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      @(negedge clk);

      // 1: reset for two cycles, BOOT cycle, then sequential fetch
      step();
      step();
      expect_f("rst", 32'h3000, 32'd1, 1'b0, 1'b0);
      reset = 1'b0;
      expect_f("boot", 32'h3000, 32'd1, 1'b0, 1'b0);
      step();
      expect_f("run0", 32'h3000, 32'd1, 1'b1, 1'b0);
      step();
      expect_f("run1", 32'h3004, 32'd2, 1'b1, 1'b0);
      step();
      expect_f("run2", 32'h3008, 32'd3, 1'b1, 1'b0);

`ifdef IM_RANGE_CHECK_EN
      // 6b: run off the end of a 4-word IM, hold, then redirect home
      step();
      expect_f("rng_last", 32'h300C, 32'd4, 1'b1, 1'b0);
      check_eq("rng_last_flt", {31'd0, range_fault_F}, 32'd0);
      step();
      expect_f("rng_flt", 32'h3010, 32'd5, 1'b0, 1'b0);
      check_eq("rng_flt_flag", {31'd0, range_fault_F}, 32'd1);
      step();
      expect_f("rng_hold", 32'h3010, 32'd5, 1'b0, 1'b0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h3000;
      step();
      redirect_valid = 1'b0;
      expect_f("rng_home", 32'h3000, 32'd1, 1'b1, 1'b0);
      check_eq("rng_home_flag", {31'd0, range_fault_F}, 32'd0);
`else
      step();
      step();
      expect_f("run4", 32'h3010, 32'd5, 1'b1, 1'b0);

      // 2: unstalled redirect visible next cycle
      redirect_valid = 1'b1;
      redirect_pc    = 32'h3100;
      step();
      redirect_valid = 1'b0;
      expect_f("redir", 32'h3100, 32'h41, 1'b1, 1'b0);

      // 3: position at 0x3020, stall 3 cycles with two redirects, last wins
      redirect_valid = 1'b1;
      redirect_pc    = 32'h3020;
      step();
      expect_f("pos3020", 32'h3020, 32'd9, 1'b1, 1'b0);
      stall_F     = 1'b1;
      redirect_pc = 32'h3200;
      step();
      expect_f("stall1", 32'h3020, 32'd9, 1'b0, 1'b1);
      redirect_pc = 32'h3300;
      step();
      expect_f("stall2", 32'h3020, 32'd9, 1'b0, 1'b1);
      redirect_valid = 1'b0;
      step();
      expect_f("stall3", 32'h3020, 32'd9, 1'b0, 1'b1);
      stall_F = 1'b0;
      step();
      expect_f("release", 32'h3300, 32'hC1, 1'b1, 1'b0);
      step();
      expect_f("after_rel", 32'h3304, 32'hC2, 1'b1, 1'b0);

      // 4: live redirect on release beats the buffered target
      stall_F        = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h3400;
      step();
      expect_f("buf3400", 32'h3304, 32'hC2, 1'b0, 1'b1);
      stall_F     = 1'b0;
      redirect_pc = 32'h3500;
      step();
      redirect_valid = 1'b0;
      expect_f("live3500", 32'h3500, 32'h141, 1'b1, 1'b0);
      step();
      expect_f("drop3400", 32'h3504, 32'h142, 1'b1, 1'b0);

      // 5: reset while a redirect is pending
      stall_F        = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h3600;
      step();
      expect_f("buf3600", 32'h3504, 32'h142, 1'b0, 1'b1);
      redirect_valid = 1'b0;
      reset          = 1'b1;
      step();
      expect_f("rst_pend", 32'h3000, 32'd1, 1'b0, 1'b0);
      reset   = 1'b0;
      stall_F = 1'b0;
      expect_f("boot2", 32'h3000, 32'd1, 1'b0, 1'b0);
      step();
      expect_f("run0b", 32'h3000, 32'd1, 1'b1, 1'b0);
      step();
      expect_f("run1b", 32'h3004, 32'd2, 1'b1, 1'b0);

      // 6: misaligned redirect accepted unchanged and flagged
      check_eq("align_ok", {31'd0, misalign_F}, 32'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h3002;
      step();
      redirect_valid = 1'b0;
      expect_f("mis0", 32'h3002, 32'd1, 1'b1, 1'b0);
      check_eq("mis0_flag", {31'd0, misalign_F}, 32'd1);
      step();
      expect_f("mis1", 32'h3006, 32'd2, 1'b1, 1'b0);
      check_eq("mis1_flag", {31'd0, misalign_F}, 32'd1);

      // Wrap: pc+4 and the below-base subtraction wrap modulo 2^32
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      expect_f("wrap_top", 32'hFFFF_FFFC, 32'h400, 1'b1, 1'b0);
      check_eq("wrap_pc4", pc4_F, 32'h0000_0000);
      step();
      expect_f("wrap_zero", 32'h0000_0000, 32'h401, 1'b1, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
